write_buffer: RTL and testbench

Posted-write buffer between the data cache and main memory. It accepts evicted dirty cachelines from the cache's write-back port, queues them in a small FIFO, and drains them to main memory over a request/acknowledge handshake. It also snoops the cache's refill reads and forwards buffered line data, so a refill never returns a stale line from memory.

---
 rtl/write_buffer_pkg.sv | 26 ++
 rtl/write_buffer_if.sv | 48 ++++
 rtl/write_buffer_wb_match.sv | 58 +++++
 rtl/write_buffer.sv | 175 +++++++++++++++++
 tb/tb_write_buffer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// write_buffer_pkg
// Shared cache/write-buffer definitions: default geometry (address width,
// cacheline width, line-offset width, buffer depth), main-memory operation
// codes and a pointer-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package write_buffer_pkg;

    localparam int unsigned WB_ADDR_WIDTH   = 32;
    localparam int unsigned WB_LINE_WIDTH   = 128;
    localparam int unsigned WB_OFFSET_WIDTH = 4;
    localparam int unsigned WB_DEPTH        = 4;

    // Main-memory operation codes shared with the cache controller.
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned wb_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/write_buffer_if.sv
// -----------------------------------------------------------------------------
// write_buffer_if
// Groups the cache write-back port, the cache refill snoop port and the
// main-memory drain handshake of the write buffer.
//   master : cache + memory side (drives wb_*, rd_en/rd_addr, mem_wr_ack)
//   slave  : write buffer side  (drives wb_full, rd_hit/rd_data, mem_wr_*)
// -----------------------------------------------------------------------------
interface write_buffer_if
    import write_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = WB_LINE_WIDTH
) ();

    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [LINE_WIDTH-1:0] wb_data;
    logic                  wb_full;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_hit;
    logic [LINE_WIDTH-1:0] rd_data;

    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [LINE_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_ack;

    modport master (
        output wb_en, wb_addr, wb_data,
        input  wb_full,
        output rd_en, rd_addr,
        input  rd_hit, rd_data,
        input  mem_wr_req, mem_wr_addr, mem_wr_data,
        output mem_wr_ack
    );

    modport slave (
        input  wb_en, wb_addr, wb_data,
        output wb_full,
        input  rd_en, rd_addr,
        output rd_hit, rd_data,
        output mem_wr_req, mem_wr_addr, mem_wr_data,
        input  mem_wr_ack
    );

endinterface

// File: rtl/write_buffer_wb_match.sv
// -----------------------------------------------------------------------------
// wb_match
// Parallel line-address comparator across all buffer entries. Reports whether
// any valid entry holds the compared line and, if several do, the index of the
// youngest one (furthest from the head in FIFO order).
// Ports:
//   i_valid    per-entry valid mask
//   i_tag      per-entry line address (offset bits already stripped)
//   i_head     FIFO head pointer (oldest entry)
//   i_cmp_tag  line address being looked up
//   o_hit      at least one valid entry matches
//   o_idx      youngest matching entry (head when no hit)
// -----------------------------------------------------------------------------
module wb_match
    import write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = WB_DEPTH,
    parameter int unsigned TAG_WIDTH = WB_ADDR_WIDTH - WB_OFFSET_WIDTH,
    parameter int unsigned PTR_W     = wb_ptr_width(WB_DEPTH)
) (
    input  logic [DEPTH-1:0]     i_valid,
    input  logic [TAG_WIDTH-1:0] i_tag [DEPTH],
    input  logic [PTR_W-1:0]     i_head,
    input  logic [TAG_WIDTH-1:0] i_cmp_tag,
    output logic                 o_hit,
    output logic [PTR_W-1:0]     o_idx
);

    logic [DEPTH-1:0] w_match;
    logic [PTR_W-1:0] w_pos [DEPTH];

    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_match[i] = i_valid[i] && (i_tag[i] == i_cmp_tag);
        end
    end

    // w_pos[k] is the entry k places after the head; pointer width wraps mod DEPTH.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_pos[k] = i_head + PTR_W'(k);
        end
    end

    // Walk oldest to youngest so the last match seen wins.
    always_comb begin
        o_hit = 1'b0;
        o_idx = i_head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_match[w_pos[k]]) begin
                o_hit = 1'b1;
                o_idx = w_pos[k];
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// -----------------------------------------------------------------------------
// write_buffer
// Posted-write buffer between the data cache and main memory. Evicted dirty
// lines are queued in a circular FIFO and drained to memory over a req/ack
// handshake; refill reads are snooped and buffered data is forwarded one
// cycle later (same latency as main memory) so a refill never sees a stale
// line.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    write_buffer_if.slave:
//            wb_en/wb_addr/wb_data -> push, wb_full back-pressure
//            rd_en/rd_addr         -> snoop, rd_hit/rd_data next cycle
//            mem_wr_req/addr/data  -> head entry, popped by mem_wr_ack
// Configuration macro: WB_COALESCE_EN -- a push matching a valid non-head
// entry overwrites that entry's data instead of allocating (also while full).
// -----------------------------------------------------------------------------
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = WB_DEPTH,
    parameter int unsigned ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH   = WB_LINE_WIDTH,
    parameter int unsigned OFFSET_WIDTH = WB_OFFSET_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    write_buffer_if.slave bus
);

    localparam int unsigned PTR_W = wb_ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = ADDR_WIDTH - OFFSET_WIDTH;

    logic [DEPTH-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [DEPTH];
    logic [LINE_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  r_rd_hit;
    logic [LINE_WIDTH-1:0] r_rd_data;

    logic [TAG_W-1:0]      w_wb_tag;
    logic [TAG_W-1:0]      w_rd_tag;
    logic                  w_full;
    logic                  w_req;
    logic                  w_pop;
    logic                  w_alloc;
    logic                  w_coal;
    logic [PTR_W-1:0]      w_coal_idx;
    logic                  w_push_any;
    logic                  w_fwd_hit;
    logic [PTR_W-1:0]      w_fwd_idx;
    logic                  w_rd_hit_nxt;
    logic [LINE_WIDTH-1:0] w_rd_data_nxt;
    logic                  w_unused_offsets;

    assign w_wb_tag = bus.wb_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign w_rd_tag = bus.rd_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign w_unused_offsets = ^{bus.wb_addr[OFFSET_WIDTH-1:0], bus.rd_addr[OFFSET_WIDTH-1:0]};

    // Full is decoded from registered count only, so a same-cycle pop never
    // frees a slot for that cycle's push.
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_req  = (r_count != '0);
    assign w_pop  = bus.mem_wr_ack && w_req;

`ifdef WB_COALESCE_EN
    // The head is locked while presented to memory, so it is excluded.
    logic [DEPTH-1:0] w_coal_valid;
    logic             w_coal_hit;

    always_comb begin
        w_coal_valid         = r_valid;
        w_coal_valid[r_head] = 1'b0;
    end

    wb_match #(
        .DEPTH    (DEPTH),
        .TAG_WIDTH(TAG_W),
        .PTR_W    (PTR_W)
    ) u_coal_match (
        .i_valid  (w_coal_valid),
        .i_tag    (r_tag),
        .i_head   (r_head),
        .i_cmp_tag(w_wb_tag),
        .o_hit    (w_coal_hit),
        .o_idx    (w_coal_idx)
    );

    assign w_coal = bus.wb_en && w_coal_hit;
`else
    assign w_coal     = 1'b0;
    assign w_coal_idx = '0;
`endif

    assign w_alloc    = bus.wb_en && !w_full && !w_coal;
    assign w_push_any = w_alloc || w_coal;

    wb_match #(
        .DEPTH    (DEPTH),
        .TAG_WIDTH(TAG_W),
        .PTR_W    (PTR_W)
    ) u_fwd_match (
        .i_valid  (r_valid),
        .i_tag    (r_tag),
        .i_head   (r_head),
        .i_cmp_tag(w_rd_tag),
        .o_hit    (w_fwd_hit),
        .o_idx    (w_fwd_idx)
    );

    // Push in flight beats stored entries; stored entries are read before any
    // same-cycle pop, so a line leaving the head still forwards.
    always_comb begin
        w_rd_hit_nxt  = 1'b0;
        w_rd_data_nxt = '0;
        if (bus.rd_en) begin
            if (w_push_any && (w_wb_tag == w_rd_tag)) begin
                w_rd_hit_nxt  = 1'b1;
                w_rd_data_nxt = bus.wb_data;
            end else if (w_fwd_hit) begin
                w_rd_hit_nxt  = 1'b1;
                w_rd_data_nxt = r_data[w_fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rd_hit  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_rd_hit  <= w_rd_hit_nxt;
            r_rd_data <= w_rd_data_nxt;
        end
    end

    // Entry payload needs no reset: r_valid and the gated outputs hide it.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[r_tail]  <= w_wb_tag;
            r_data[r_tail] <= bus.wb_data;
        end
        if (w_coal) begin
            r_data[w_coal_idx] <= bus.wb_data;
        end
    end

    assign bus.wb_full     = w_full;
    assign bus.mem_wr_req  = w_req;
    assign bus.mem_wr_addr = w_req ? {r_tag[r_head], {OFFSET_WIDTH{1'b0}}} : '0;
    assign bus.mem_wr_data = w_req ? r_data[r_head] : '0;
    assign bus.rd_hit      = r_rd_hit;
    assign bus.rd_data     = r_rd_data;

endmodule

// File: tb/tb_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_write_buffer
// Directed then random stimulus for write_buffer; expected outputs come from a
// queue-based model of the posted-write buffer kept in this bench.
// Honours WB_COALESCE_EN in the model when the macro is defined.
// -----------------------------------------------------------------------------
module tb_write_buffer;
    import write_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 128;
    localparam int unsigned OW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    write_buffer_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus_if ();

    write_buffer #(
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .LINE_WIDTH  (LW),
        .OFFSET_WIDTH(OW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    typedef struct {
        logic [AW-OW-1:0] line;
        logic [LW-1:0]    data;
    } ent_t;

    ent_t          q[$];
    logic          exp_hit;
    logic [LW-1:0] exp_rdata;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_data;
        exp_addr = '0;
        exp_data = '0;
        if (q.size() != 0) begin
            exp_addr = {q[0].line, {OW{1'b0}}};
            exp_data = q[0].data;
        end
        chk({tag, ".full"},  LW'(bus_if.wb_full),     LW'(q.size() == DEPTH));
        chk({tag, ".req"},   LW'(bus_if.mem_wr_req),  LW'(q.size() != 0));
        chk({tag, ".waddr"}, LW'(bus_if.mem_wr_addr), LW'(exp_addr));
        chk({tag, ".wdata"}, bus_if.mem_wr_data,      exp_data);
        chk({tag, ".hit"},   LW'(bus_if.rd_hit),      LW'(exp_hit));
        chk({tag, ".rdata"}, bus_if.rd_data,          exp_rdata);
    endtask

    // One clock cycle: apply inputs, predict, clock, update model, compare.
    task automatic step(input string tag,
                        input logic we, input logic [AW-1:0] wa, input logic [LW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra, input logic ack);
        logic full;
        logic coal;
        logic accepted;
        int   cidx;
        bus_if.wb_en      = we;
        bus_if.wb_addr    = wa;
        bus_if.wb_data    = wd;
        bus_if.rd_en      = re;
        bus_if.rd_addr    = ra;
        bus_if.mem_wr_ack = ack;
        full = (q.size() == DEPTH);
        coal = 1'b0;
        cidx = -1;
`ifdef WB_COALESCE_EN
        if (we) begin
            for (int i = q.size() - 1; i >= 1; i--) begin
                if (q[i].line == wa[AW-1:OW]) begin
                    coal = 1'b1;
                    cidx = i;
                    break;
                end
            end
        end
`endif
        accepted  = we && (coal || !full);
        exp_hit   = 1'b0;
        exp_rdata = '0;
        if (re) begin
            if (accepted && (wa[AW-1:OW] == ra[AW-1:OW])) begin
                exp_hit   = 1'b1;
                exp_rdata = wd;
            end else begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].line == ra[AW-1:OW]) begin
                        exp_hit   = 1'b1;
                        exp_rdata = q[i].data;
                        break;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (coal) q[cidx].data = wd;
        if (ack && q.size() != 0) void'(q.pop_front());
        if (we && !coal && !full) q.push_back('{wa[AW-1:OW], wd});
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic ack_one(input string tag);
        step(tag, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(1, 6)) << 8;
        return a | AW'($urandom_range(0, 15));
    endfunction

    initial begin
        bus_if.wb_en      = 1'b0;
        bus_if.wb_addr    = '0;
        bus_if.wb_data    = '0;
        bus_if.rd_en      = 1'b0;
        bus_if.rd_addr    = '0;
        bus_if.mem_wr_ack = 1'b0;
        exp_hit           = 1'b0;
        exp_rdata         = '0;

        // Reset state
        #12;
        check_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push then ack
        step("push1", 1'b1, 32'h0000_0100, 128'h1, 1'b0, '0, 1'b0);
        idle("hold1");
        ack_one("ack1");
        ack_one("ack_idle");

        // Fill, overflow ignored, drain in order
        step("fill0", 1'b1, 32'h100, 128'h11, 1'b0, '0, 1'b0);
        step("fill1", 1'b1, 32'h200, 128'h22, 1'b0, '0, 1'b0);
        step("fill2", 1'b1, 32'h300, 128'h33, 1'b0, '0, 1'b0);
        step("fill3", 1'b1, 32'h400, 128'h44, 1'b0, '0, 1'b0);
        step("over",  1'b1, 32'h500, 128'h55, 1'b0, '0, 1'b0);
        step("over_rd", 1'b0, '0, '0, 1'b1, 32'h500, 1'b0);
        step("full_pushpop", 1'b1, 32'h600, 128'h66, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) ack_one("drain");

        // Forwarding hit / miss
        step("push_aa", 1'b1, 32'h200, 128'hAA, 1'b0, '0, 1'b0);
        step("rd_hit",  1'b0, '0, '0, 1'b1, 32'h208, 1'b0);
        step("rd_miss", 1'b0, '0, '0, 1'b1, 32'h900, 1'b0);

        // Push in flight forwards
        step("push_rd_bb", 1'b1, 32'h300, 128'hBB, 1'b1, 32'h300, 1'b0);
        step("pop_rd", 1'b0, '0, '0, 1'b1, 32'h20C, 1'b1);
        ack_one("drain_bb");

        // Duplicate line: coalesced or allocated depending on build
        step("dup0", 1'b1, 32'h100, 128'h1, 1'b0, '0, 1'b0);
        step("dup1", 1'b1, 32'h200, 128'h2, 1'b0, '0, 1'b0);
        step("dup2", 1'b1, 32'h200, 128'h3, 1'b0, '0, 1'b0);
        step("dup_rd", 1'b0, '0, '0, 1'b1, 32'h200, 1'b0);
        step("dup_fill", 1'b1, 32'h700, 128'h7, 1'b0, '0, 1'b0);
        step("dup_fill2", 1'b1, 32'h800, 128'h8, 1'b0, '0, 1'b0);
        step("dup_full_push", 1'b1, 32'h700, 128'h77, 1'b1, 32'h700, 1'b0);
        for (int i = 0; i < 5; i++) ack_one("dup_drain");

        // Asynchronous reset mid-handshake
        step("rst_p0", 1'b1, 32'h100, 128'hC1, 1'b0, '0, 1'b0);
        step("rst_p1", 1'b1, 32'h200, 128'hC2, 1'b0, '0, 1'b0);
        step("rst_p2", 1'b1, 32'h300, 128'hC3, 1'b0, '0, 1'b0);
        step("rst_p3", 1'b1, 32'h400, 128'hC4, 1'b1, 32'h100, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_hit   = 1'b0;
        exp_rdata = '0;
        check_outputs("rst_async");
        #3;
        rst_n = 1'b1;
        idle("rst_after");
        step("rst_push", 1'b1, 32'h500, 128'hD5, 1'b0, '0, 1'b0);
        ack_one("rst_ack");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 1'($urandom_range(0, 1)), rand_addr(),
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), rand_addr(),
                 ($urandom_range(0, 9) < 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
